// File: rtl/sync_fifo_pkg.sv
// Shared width helpers, type templates and parameter legality checks for sync_fifo.
package sync_fifo_pkg;

    localparam int unsigned DEPTH_MIN     = 2;
    localparam int unsigned DEFAULT_DEPTH = 16;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return ptr_w(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(
        input int unsigned data_w,
        input int unsigned depth,
        input int unsigned afull,
        input int unsigned aempty
    );
        return (data_w >= 1) && (depth >= DEPTH_MIN) && is_pow2(depth) &&
               (afull >= 1) && (afull <= depth) && (aempty <= depth - 1);
    endfunction

    // Templates for the default depth; instances re-derive these from their own DEPTH.
    typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] ptr_t;
    typedef logic [cnt_w(DEFAULT_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write, asynchronous read, no reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO with level count, almost flags and synchronous flush.
// Optional sticky ovf_err/udf_err ports are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = 12,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                     ovf_err,
    output logic                     udf_err
`endif
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    typedef logic [PTR_W-1:0] fifo_ptr_t;
    typedef logic [CNT_W-1:0] fifo_cnt_t;

    localparam fifo_cnt_t CNT_FULL   = fifo_cnt_t'(DEPTH);
    localparam fifo_cnt_t CNT_AFULL  = fifo_cnt_t'(AFULL_THRESH);
    localparam fifo_cnt_t CNT_AEMPTY = fifo_cnt_t'(AEMPTY_THRESH);

    if (!params_ok(DATA_W, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_chk
        $error("sync_fifo: illegal parameters DATA_W=%0d DEPTH=%0d AFULL=%0d AEMPTY=%0d",
               DATA_W, DEPTH, AFULL_THRESH, AEMPTY_THRESH);
    end

    fifo_ptr_t wr_ptr_q, wr_ptr_d;
    fifo_ptr_t rd_ptr_q, rd_ptr_d;
    fifo_cnt_t count_q, count_d;
    logic      full_q, empty_q, afull_q, aempty_q;
    logic      push_ok, pop_ok;
    logic [DATA_W-1:0] head_data;

    always_comb begin
        push_ok  = wr_en & (~full_q | rd_en);
        pop_ok   = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + fifo_ptr_t'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + fifo_ptr_t'(1);
            count_d = count_q + fifo_cnt_t'(push_ok) - fifo_cnt_t'(pop_ok);
        end
    end

    // Flags are computed from the next count so they are valid in the same cycle as count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= CNT_AFULL);
            aempty_q <= (count_d <= CNT_AEMPTY);
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_ok & ~flush & ~rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data)
    );

    assign rd_data      = empty_q ? '0 : head_data;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en & full_q & ~rd_en) ovf_q <= 1'b1;
            if (rd_en & empty_q)         udf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo at DATA_W=8, DEPTH=16, thresholds 12/4.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic       ovf_err, udf_err;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_W        (8),
        .DEPTH         (16),
        .AFULL_THRESH  (12),
        .AEMPTY_THRESH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0; wr_data = 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
        tick();
        idle();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
`ifdef SYNC_FIFO_ERR_EN
        chk("rst_ovf", ovf_err, 0);
        chk("rst_udf", udf_err, 0);
`endif

        // Fill 0x01..0x10, checking latency and threshold crossings on the way up.
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            if (i == 1) begin
                chk("fwft_rd_data", rd_data, 8'h01);
                chk("fwft_empty", empty, 0);
            end
            if (i == 4)  chk("ae_at4_up", almost_empty, 1);
            if (i == 5)  chk("ae_at5_up", almost_empty, 0);
            if (i == 11) chk("af_at11", almost_full, 0);
            if (i == 12) chk("af_at12", almost_full, 1);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);

        // Rejected push while full: nothing changes, head stays 0x01.
        wr_en = 1'b1; wr_data = 8'hAA;
        tick();
        idle();
        chk("ovf_count", count, 16);
        chk("ovf_head", rd_data, 8'h01);
`ifdef SYNC_FIFO_ERR_EN
        chk("ovf_err_set", ovf_err, 1);
`endif

        for (int i = 1; i <= 16; i++) begin
            pop_check("drain_order", 8'(i));
            if (i == 11) chk("ae_at5_down", almost_empty, 0);
            if (i == 12) chk("ae_at4_down", almost_empty, 1);
        end
        chk("drain_empty", empty, 1);
        chk("drain_rd_data", rd_data, 0);
        chk("drain_count", count, 0);

        // Rejected pop on empty.
        rd_en = 1'b1;
        tick();
        idle();
        chk("udf_count", count, 0);
        chk("udf_empty", empty, 1);
`ifdef SYNC_FIFO_ERR_EN
        chk("udf_err_set", udf_err, 1);
        chk("ovf_err_sticky", ovf_err, 1);
        flush = 1'b1;
        tick();
        idle();
        chk("flush_clr_ovf", ovf_err, 0);
        chk("flush_clr_udf", udf_err, 0);
`endif

        // Empty with push+pop: push only.
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
        tick();
        idle();
        chk("empty_wr_rd_count", count, 1);
        pop_check("empty_wr_rd_data", 8'h99);

        // Full with simultaneous push/pop across the pointer wrap.
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        for (int k = 0; k < 8; k++) begin
            chk("wrap_head", rd_data, 8'h20 + 8'(k));
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h40 + 8'(k);
            tick();
            idle();
            chk("wrap_count", count, 16);
            chk("wrap_full", full, 1);
        end
        for (int i = 8; i < 16; i++) pop_check("wrap_old", 8'h20 + 8'(i));
        for (int k = 0; k < 8; k++)  pop_check("wrap_new", 8'h40 + 8'(k));
        chk("wrap_empty", empty, 1);

        // Flush overrides a concurrent push.
        for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
        chk("pre_flush_count", count, 10);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        idle();
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_rd_data", rd_data, 0);
        chk("flush_aempty", almost_empty, 1);
        push(8'h77);
        chk("post_flush_head", rd_data, 8'h77);
        chk("post_flush_count", count, 1);

        // Reset mid-burst wins over a concurrent push.
        push(8'h11);
        push(8'h12);
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h13;
        tick();
        idle();
        chk("rst_mid_count", count, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_rd_data", rd_data, 0);
        push(8'h5A);
        chk("post_rst_head", rd_data, 8'h5A);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
